// File: rtl/pinwheel_regfile_port.sv
// pinwheel_regfile_port
// Client-side controller for the pinwheel barrel-threaded register file.
// It owns both read ports and the shared write port of the dual-bank RAM.
// After reset it sweeps every entry to zero, because the block RAM has no
// reset of its own. In RUN it turns per-thread fetch requests into flat
// {thread, reg} addresses and returns operands one cycle later. Those
// operands have x0 forced to zero and a same-cycle writeback forwarded, since
// the RAM returns old data on read-during-write.

module pinwheel_regfile_port #(
    parameter int reg_count    = 32,
    parameter int reg_width    = 32,
    parameter int thread_count = 4,
    localparam int reg_bits    = $clog2(reg_count),
    localparam int thread_bits = $clog2(thread_count),
    localparam int addr_bits   = $clog2(reg_count * thread_count),
    localparam int reg_total   = reg_count * thread_count
) (
    input  logic                   clk,
    input  logic                   rst,
    // operand fetch request
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [thread_bits-1:0] req_thread,
    input  logic [reg_bits-1:0]    req_rs1,
    input  logic [reg_bits-1:0]    req_rs2,
    // operand return
    output logic                   op_valid,
    output logic [thread_bits-1:0] op_thread,
    output logic [reg_width-1:0]   op_rs1data,
    output logic [reg_width-1:0]   op_rs2data,
    // writeback
    input  logic                   wb_valid,
    input  logic [thread_bits-1:0] wb_thread,
    input  logic [reg_bits-1:0]    wb_rd,
    input  logic [reg_width-1:0]   wb_data,
    // status
    output logic                   busy,
    // regfile RAM side
    output logic [addr_bits-1:0]   rf_raddr0,
    output logic [addr_bits-1:0]   rf_raddr1,
    input  logic [reg_width-1:0]   rf_rdata0,
    input  logic [reg_width-1:0]   rf_rdata1,
    output logic [addr_bits-1:0]   rf_waddr,
    output logic [reg_width-1:0]   rf_wdata,
    output logic                   rf_wren
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [addr_bits-1:0] CLR_ZERO  = {addr_bits{1'b0}};
    localparam logic [addr_bits-1:0] CLR_ONE   = addr_bits'(1);
    localparam logic [addr_bits-1:0] CLR_LAST  = addr_bits'(reg_total - 1);
    localparam logic [reg_width-1:0] ZERO_WORD = {reg_width{1'b0}};
    localparam logic [reg_bits-1:0]  REG_X0    = {reg_bits{1'b0}};
    localparam logic [thread_bits-1:0] THREAD_ZERO = {thread_bits{1'b0}};

    // Flat regfile address: thread index in the upper bits, register below.
    function automatic logic [addr_bits-1:0] flat_addr(
        input logic [thread_bits-1:0] thread_idx,
        input logic [reg_bits-1:0]    reg_idx
    );
        flat_addr = addr_bits'({thread_idx, reg_idx});
    endfunction

    // Operand select: x0 wins, then the forwarded same-cycle write, then RAM.
    function automatic logic [reg_width-1:0] pick_operand(
        input logic                 zero_flag,
        input logic                 byp_flag,
        input logic [reg_width-1:0] byp_data,
        input logic [reg_width-1:0] ram_data
    );
        if (zero_flag) begin
            pick_operand = ZERO_WORD;
        end else if (byp_flag) begin
            pick_operand = byp_data;
        end else begin
            pick_operand = ram_data;
        end
    endfunction

    // FSM and sweep counter
    state_t                 state_q, state_d;
    logic [addr_bits-1:0]   clr_idx_q, clr_idx_d;

    // Operand pipeline stage (captured at acceptance, used one cycle later)
    logic                   op_valid_q, op_valid_d;
    logic [thread_bits-1:0] op_thread_q, op_thread_d;
    logic                   rs1_zero_q, rs1_zero_d;
    logic                   rs2_zero_q, rs2_zero_d;
    logic                   rs1_byp_q, rs1_byp_d;
    logic                   rs2_byp_q, rs2_byp_d;
    logic [reg_width-1:0]   byp_data_q, byp_data_d;

    // Combinational helpers
    logic                   req_ready_s;
    logic                   busy_s;
    logic                   rf_wren_s;
    logic [addr_bits-1:0]   rf_waddr_s;
    logic [reg_width-1:0]   rf_wdata_s;
    logic                   accept_s;
    logic                   wb_eff_s;
    logic [addr_bits-1:0]   wb_addr_s;
    logic [addr_bits-1:0]   raddr0_s;
    logic [addr_bits-1:0]   raddr1_s;
    logic                   byp0_s;
    logic                   byp1_s;
    logic [reg_width-1:0]   op_rs1data_s;
    logic [reg_width-1:0]   op_rs2data_s;

    // Read addresses go straight to the RAM so data lands the next cycle.
    always_comb begin
        raddr0_s = flat_addr(req_thread, req_rs1);
        raddr1_s = flat_addr(req_thread, req_rs2);
    end

    // Writeback qualification and same-cycle collision detection per port.
    always_comb begin
        wb_addr_s = flat_addr(wb_thread, wb_rd);
        wb_eff_s  = wb_valid & (wb_rd != REG_X0) & (state_q == ST_RUN) & ~rst;
        byp0_s    = wb_eff_s & (wb_addr_s == raddr0_s);
        byp1_s    = wb_eff_s & (wb_addr_s == raddr1_s);
        accept_s  = req_valid & req_ready_s;
    end

    // FSM state register and clear-sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= CLR_ZERO;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // FSM next state: sweep every entry once, then stay in RUN until reset.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_idx_q == CLR_LAST) begin
                    state_d   = ST_RUN;
                    clr_idx_d = CLR_ZERO;
                end else begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = clr_idx_q + CLR_ONE;
                end
            end
            ST_RUN: begin
                state_d   = ST_RUN;
                clr_idx_d = CLR_ZERO;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = CLR_ZERO;
            end
        endcase
    end

    // FSM outputs: the sweep owns the write port in CLEAR, writeback in RUN.
    always_comb begin
        req_ready_s = 1'b0;
        busy_s      = 1'b1;
        rf_wren_s   = 1'b0;
        rf_waddr_s  = CLR_ZERO;
        rf_wdata_s  = ZERO_WORD;
        if (rst) begin
            req_ready_s = 1'b0;
            busy_s      = 1'b1;
            rf_wren_s   = 1'b0;
            rf_waddr_s  = CLR_ZERO;
            rf_wdata_s  = ZERO_WORD;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    req_ready_s = 1'b0;
                    busy_s      = 1'b1;
                    rf_wren_s   = 1'b1;
                    rf_waddr_s  = clr_idx_q;
                    rf_wdata_s  = ZERO_WORD;
                end
                ST_RUN: begin
                    req_ready_s = 1'b1;
                    busy_s      = 1'b0;
                    rf_wren_s   = wb_eff_s;
                    rf_waddr_s  = wb_addr_s;
                    rf_wdata_s  = wb_data;
                end
                default: begin
                    req_ready_s = 1'b0;
                    busy_s      = 1'b1;
                    rf_wren_s   = 1'b0;
                    rf_waddr_s  = CLR_ZERO;
                    rf_wdata_s  = ZERO_WORD;
                end
            endcase
        end
    end

    // Operand stage next state: capture flags and forwarded data on accept.
    always_comb begin
        op_valid_d  = accept_s;
        op_thread_d = op_thread_q;
        rs1_zero_d  = rs1_zero_q;
        rs2_zero_d  = rs2_zero_q;
        rs1_byp_d   = rs1_byp_q;
        rs2_byp_d   = rs2_byp_q;
        byp_data_d  = byp_data_q;
        if (accept_s) begin
            op_thread_d = req_thread;
            rs1_zero_d  = (req_rs1 == REG_X0);
            rs2_zero_d  = (req_rs2 == REG_X0);
            rs1_byp_d   = byp0_s;
            rs2_byp_d   = byp1_s;
            byp_data_d  = wb_data;
        end else begin
            op_thread_d = op_thread_q;
            rs1_zero_d  = rs1_zero_q;
            rs2_zero_d  = rs2_zero_q;
            rs1_byp_d   = rs1_byp_q;
            rs2_byp_d   = rs2_byp_q;
            byp_data_d  = byp_data_q;
        end
    end

    // Operand stage registers; reset kills any in-flight operand and
    // parks the zero flags so the data outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_q  <= 1'b0;
            op_thread_q <= THREAD_ZERO;
            rs1_zero_q  <= 1'b1;
            rs2_zero_q  <= 1'b1;
            rs1_byp_q   <= 1'b0;
            rs2_byp_q   <= 1'b0;
            byp_data_q  <= ZERO_WORD;
        end else begin
            op_valid_q  <= op_valid_d;
            op_thread_q <= op_thread_d;
            rs1_zero_q  <= rs1_zero_d;
            rs2_zero_q  <= rs2_zero_d;
            rs1_byp_q   <= rs1_byp_d;
            rs2_byp_q   <= rs2_byp_d;
            byp_data_q  <= byp_data_d;
        end
    end

    // Final operand mux against the RAM data arriving this cycle.
    always_comb begin
        op_rs1data_s = pick_operand(rs1_zero_q, rs1_byp_q, byp_data_q, rf_rdata0);
        op_rs2data_s = pick_operand(rs2_zero_q, rs2_byp_q, byp_data_q, rf_rdata1);
    end

    assign req_ready  = req_ready_s;
    assign busy       = busy_s;
    assign rf_raddr0  = raddr0_s;
    assign rf_raddr1  = raddr1_s;
    assign rf_wren    = rf_wren_s;
    assign rf_waddr   = rf_waddr_s;
    assign rf_wdata   = rf_wdata_s;
    assign op_valid   = op_valid_q;
    assign op_thread  = op_thread_q;
    assign op_rs1data = op_rs1data_s;
    assign op_rs2data = op_rs2data_s;

endmodule

// File: tb/tb_pinwheel_regfile_port.sv
// Self-checking bench for pinwheel_regfile_port: a behavioural RAM with
// read-old-data semantics plus an architectural register-file model.
module tb_pinwheel_regfile_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_thread;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        op_valid;
    logic [1:0]  op_thread;
    logic [31:0] op_rs1data;
    logic [31:0] op_rs2data;
    logic        wb_valid;
    logic [1:0]  wb_thread;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic [6:0]  rf_raddr0;
    logic [6:0]  rf_raddr1;
    logic [31:0] rf_rdata0;
    logic [31:0] rf_rdata1;
    logic [6:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wren;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view: reads in a cycle see that cycle's write.
    logic [31:0] model_regs [0:3][0:31];
    bit          model_run = 1'b0;

    // RAM model: unwritten entries return a recognisable non-zero pattern.
    logic [31:0] ram [0:127];
    bit          ram_valid [0:127];

    pinwheel_regfile_port dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_thread (req_thread),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .op_valid   (op_valid),
        .op_thread  (op_thread),
        .op_rs1data (op_rs1data),
        .op_rs2data (op_rs2data),
        .wb_valid   (wb_valid),
        .wb_thread  (wb_thread),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .busy       (busy),
        .rf_raddr0  (rf_raddr0),
        .rf_raddr1  (rf_raddr1),
        .rf_rdata0  (rf_rdata0),
        .rf_rdata1  (rf_rdata1),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_wren    (rf_wren)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read-old-data on same-address write.
    always @(posedge clk) begin
        if (rf_wren) begin
            ram[rf_waddr]       <= rf_wdata;
            ram_valid[rf_waddr] <= 1'b1;
        end
        rf_rdata0 <= ram_valid[rf_raddr0] ? ram[rf_raddr0] : {25'h1A5A5A5, rf_raddr0};
        rf_rdata1 <= ram_valid[rf_raddr1] ? ram[rf_raddr1] : {25'h1A5A5A5, rf_raddr1};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 32; r++) begin
                model_regs[t][r] = 32'h0;
            end
        end
    endtask

    task automatic set_idle();
        req_valid  = 1'b0;
        req_thread = 2'd0;
        req_rs1    = 5'd0;
        req_rs2    = 5'd0;
        wb_valid   = 1'b0;
        wb_thread  = 2'd0;
        wb_rd      = 5'd0;
        wb_data    = 32'h0;
    endtask

    // Hold reset for ncyc edges, then release and verify the full clear sweep.
    task automatic do_reset(input int ncyc);
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_thread = 2'd1;
        req_rs1    = 5'd7;
        req_rs2    = 5'd3;
        wb_valid   = 1'b1;
        wb_thread  = 2'd1;
        wb_rd      = 5'd3;
        wb_data    = 32'hCAFE_F00D;
        model_run  = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_op_valid", 32'(op_valid), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd1);
            check_eq("rst_ready", 32'(req_ready), 32'd0);
            check_eq("rst_wren", 32'(rf_wren), 32'd0);
            check_eq("rst_waddr", 32'(rf_waddr), 32'd0);
            check_eq("rst_wdata", rf_wdata, 32'd0);
            check_eq("rst_op_thread", 32'(op_thread), 32'd0);
            check_eq("rst_op_rs1", op_rs1data, 32'd0);
            check_eq("rst_op_rs2", op_rs2data, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 128; i++) begin
            wb_valid = 1'b1;
            wb_data  = $urandom | 32'h1;
            wb_rd    = 5'($urandom_range(1, 31));
            #1;
            check_eq("clr_wren", 32'(rf_wren), 32'd1);
            check_eq("clr_waddr", 32'(rf_waddr), 32'(i));
            check_eq("clr_wdata", rf_wdata, 32'd0);
            check_eq("clr_busy", 32'(busy), 32'd1);
            check_eq("clr_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            check_eq("clr_op_valid", 32'(op_valid), 32'd0);
        end
        set_idle();
        #1;
        check_eq("run_ready", 32'(req_ready), 32'd1);
        check_eq("run_busy", 32'(busy), 32'd0);
        check_eq("run_wren_idle", 32'(rf_wren), 32'd0);
        model_run = 1'b1;
        model_clear();
    endtask

    // One RUN cycle: drive request and writeback, check the write port,
    // then check the returned operands one cycle later.
    task automatic drive_cycle(input bit rv, input bit [1:0] rt, input bit [4:0] r1,
                               input bit [4:0] r2, input bit wv, input bit [1:0] wt,
                               input bit [4:0] wr, input bit [31:0] wd);
        bit          exp_acc;
        bit          eff;
        logic [31:0] e1;
        logic [31:0] e2;
        req_valid  = rv;
        req_thread = rt;
        req_rs1    = r1;
        req_rs2    = r2;
        wb_valid   = wv;
        wb_thread  = wt;
        wb_rd      = wr;
        wb_data    = wd;
        #1;
        exp_acc = rv && model_run;
        eff     = model_run && wv && (wr != 5'd0);
        check_eq("wren", 32'(rf_wren), 32'(eff));
        if (eff) begin
            check_eq("waddr", 32'(rf_waddr), 32'(wt) * 32'd32 + 32'(wr));
            check_eq("wdata", rf_wdata, wd);
        end
        if (rv) begin
            check_eq("raddr0", 32'(rf_raddr0), 32'(rt) * 32'd32 + 32'(r1));
            check_eq("raddr1", 32'(rf_raddr1), 32'(rt) * 32'd32 + 32'(r2));
        end
        e1 = 32'h0;
        e2 = 32'h0;
        if (exp_acc) begin
            if (r1 != 5'd0) e1 = (eff && wt == rt && wr == r1) ? wd : model_regs[rt][r1];
            if (r2 != 5'd0) e2 = (eff && wt == rt && wr == r2) ? wd : model_regs[rt][r2];
        end
        if (eff) model_regs[wt][wr] = wd;
        @(posedge clk);
        #1;
        check_eq("op_valid", 32'(op_valid), 32'(exp_acc));
        if (exp_acc) begin
            check_eq("op_thread", 32'(op_thread), 32'(rt));
            check_eq("op_rs1data", op_rs1data, e1);
            check_eq("op_rs2data", op_rs2data, e2);
        end
        set_idle();
    endtask

    initial begin
        bit [1:0]  rt;
        bit [1:0]  wt;
        bit [4:0]  r1;
        bit [4:0]  r2;
        bit [4:0]  wr;
        set_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset(2);

        // freshly cleared entry
        drive_cycle(1'b1, 2'd3, 5'd31, 5'd30, 1'b0, 2'd0, 5'd0, 32'h0);

        // basic write, then read two cycles later
        drive_cycle(1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 2'd1, 5'd7, 32'hDEADBEEF);
        drive_cycle(1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 32'h0);
        drive_cycle(1'b1, 2'd1, 5'd7, 5'd0, 1'b0, 2'd0, 5'd0, 32'h0);

        // same-cycle bypass on both ports, and thread isolation
        drive_cycle(1'b0, 2'd0, 5'd0, 5'd0, 1'b1, 2'd0, 5'd5, 32'hA5A5_0005);
        drive_cycle(1'b1, 2'd2, 5'd5, 5'd5, 1'b1, 2'd2, 5'd5, 32'h12345678);
        drive_cycle(1'b1, 2'd0, 5'd5, 5'd5, 1'b1, 2'd2, 5'd5, 32'h87654321);
        drive_cycle(1'b1, 2'd0, 5'd5, 5'd7, 1'b1, 2'd1, 5'd5, 32'h0BAD_0BAD);

        // x0 write is dropped and x0 reads as zero
        drive_cycle(1'b1, 2'd0, 5'd0, 5'd0, 1'b1, 2'd0, 5'd0, 32'hFFFFFFFF);
        drive_cycle(1'b1, 2'd0, 5'd0, 5'd5, 1'b0, 2'd0, 5'd0, 32'h0);

        // back-to-back random stream
        for (int i = 0; i < 200; i++) begin
            rt = 2'($urandom_range(0, 3));
            r1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));
            wt = 2'($urandom_range(0, 3));
            wr = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: begin wt = rt; wr = r1; end
                1: begin wt = rt; wr = r2; end
                default: begin end
            endcase
            drive_cycle(1'b1, rt, r1, r2, ($urandom_range(0, 3) != 0), wt, wr, $urandom);
        end

        // reset in the cycle after an accepted request
        drive_cycle(1'b1, 2'd1, 5'd7, 5'd5, 1'b1, 2'd3, 5'd9, 32'h5555_AAAA);
        do_reset(2);
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 32; r++) begin
                drive_cycle(1'b1, 2'(t), 5'(r), 5'(31 - r), 1'b0, 2'd0, 5'd0, 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pinwheel_regfile_port.md
# pinwheel_regfile_port

Client-side controller for the pinwheel barrel-threaded register file. Owns both read ports and the write port of the dual-bank regfile: turns per-thread operand-fetch requests into flat regfile addresses, returns operands one cycle later, and drives writeback. After every reset it clears all entries to zero, because block RAM has no reset. It also enforces x0 = 0 and forwards same-cycle writes past the RAM's read-old-data behaviour.

## Interface
Parameters:
- reg_count, 32, architectural registers per thread
- reg_width, 32, register width in bits
- thread_count, 4, hardware threads
- Derived (localparam): reg_bits = $clog2(reg_count), thread_bits = $clog2(thread_count), addr_bits = $clog2(reg_count*thread_count), reg_total = reg_count*thread_count

Ports:
- clk  in  1  clock; the only clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  operand fetch request
- req_ready  out  1  high only in RUN
- req_thread  in  thread_bits  requesting thread
- req_rs1, req_rs2  in  reg_bits  source register indices
- op_valid  out  1  operands valid this cycle
- op_thread  out  thread_bits  thread of returned operands
- op_rs1data, op_rs2data  out  reg_width  operand values
- wb_valid  in  1  writeback request
- wb_thread  in  thread_bits  writeback thread
- wb_rd  in  reg_bits  destination register
- wb_data  in  reg_width  writeback data
- busy  out  1  high while the clear sweep is in progress
- rf_raddr0, rf_raddr1  out  addr_bits  regfile read addresses
- rf_rdata0, rf_rdata1  in  reg_width  regfile read data, valid the cycle after the address
- rf_waddr  out  addr_bits  regfile write address
- rf_wdata  out  reg_width  regfile write data
- rf_wren  out  1  regfile write enable; writes both banks

## Operation
- Flat address is {thread, reg}. Example: thread 2, reg 5 gives address 69 for the default parameters.
- States:
  - CLEAR: counter clr_idx sweeps 0..reg_total-1. Each cycle drives rf_wren=1, rf_waddr=clr_idx, rf_wdata=0. In the cycle clr_idx=reg_total-1, the next state is RUN.
  - RUN: normal operation. There is no exit except reset.
- Reset:
  - rst high at an edge sets the state to CLEAR, clr_idx to 0 and op_valid to 0.
  - While rst is high, rf_wren is held at 0 and clr_idx stays at 0.
  - Reset asserted mid-RUN or mid-CLEAR aborts any in-flight operand: op_valid is 0 in the following cycle. The sweep then restarts from 0.
- CLEAR behaviour:
  - req_ready=0 and busy=1.
  - Requests are not accepted.
  - wb_valid is ignored and the write is dropped. The pipeline upstream is empty after reset, so no data is lost.
- RUN read path:
  - A request is accepted when req_valid && req_ready.
  - rf_raddr0 = {req_thread, req_rs1} and rf_raddr1 = {req_thread, req_rs2}. Both are combinational from the request.
- RUN write path:
  - A write is effective when wb_valid && wb_rd != 0.
  - rf_wren = effective, rf_waddr = {wb_thread, wb_rd}, rf_wdata = wb_data.
  - A writeback to x0 produces no write.
- Regfile read-during-write to the same address returns old data. This block compensates:
  - At acceptance (cycle N), register for each port: a zero flag (rs == 0) and a bypass flag (effective write && write address == read address). Also register wb_data and req_thread.
  - At N+1, each operand is: 0 if the zero flag is set; else the registered wb_data if the bypass flag is set; else rf_rdataX.
- Both ports bypass independently; rs1 == rs2 is legal.
- Writes at N-1 or earlier need no bypass; the RAM already holds them.
- Threads are isolated: a write to thread 1 never bypasses into a thread 0 read of the same rd.

## Timing
- Reset values: op_valid 0, op_thread 0, op_rs1data 0, op_rs2data 0, req_ready 0, busy 1, rf_wren 0, rf_waddr 0, rf_wdata 0.
- Clear duration: exactly reg_total cycles after rst falls. With defaults, the first cycle after rst falls writes address 0 and the 128th writes address 127. req_ready rises and busy falls on the 129th cycle.
- Read latency is 1 cycle: a request accepted at N produces op_valid=1 at N+1 with op_thread = the thread of the N request.
- The operand side has no backpressure. One request per cycle is sustained indefinitely.
- A writeback can be accepted every cycle in RUN, concurrent with a request.

## Test plan
- Clear sweep: pulse rst for 2 cycles, then release. Required: rf_wren high for exactly 128 cycles with rf_waddr 0..127 and rf_wdata 0, then req_ready=1; a read of thread 3 reg 31 returns 0.
- Basic write/read: write thread 1 r7 = 0xDEADBEEF, read thread 1 rs1=7 two cycles later. Required: op_rs1data = 0xDEADBEEF one cycle after the request.
- Same-cycle bypass: write thread 2 r5 = 0x12345678 in the same cycle as a request for thread 2 rs1=5, rs2=5. Required: both operands 0x12345678. A thread 0 rs1=5 request in that cycle must return the old thread 0 value.
- x0: write thread 0 r0 = 0xFFFFFFFF. Required: rf_wren stays 0, and a read of rs1=0, rs2=0 returns 0/0 even with a same-cycle bypass candidate.
- Reset mid-operation: assert rst in the cycle after a request is accepted. Required: op_valid=0 next cycle, busy=1, the sweep restarts from address 0, and all registers read 0 afterwards.
- Back-to-back stream: 200 random requests and writebacks, checked against a reference model. Required: every op_valid cycle matches the model, with no gaps.
